// File: rtl/booking_pkg.sv
// Shared constants and FSM encoding for the seat-booking scheduler.
package booking_pkg;
  localparam int NUM_TRAINS  = 4;
  localparam int CAPACITY    = 9;
  localparam int FARE_MAX    = 900;
  localparam int LOCK_THRESH = 3;
  localparam int FARE_W      = 10;
  localparam int CNT_W       = 4;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_COMMIT = 3'd1;
  localparam state_t ST_SAMPLE = 3'd2;
  localparam state_t ST_CHECK  = 3'd3;
  localparam state_t ST_HEAL   = 3'd4;
  localparam state_t ST_LOCKED = 3'd5;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/booking_if.sv
// Requester and fault-detector signals of the booking scheduler.
interface booking_if #(parameter int NUM_TRAINS = booking_pkg::NUM_TRAINS);
  import booking_pkg::*;

  logic [NUM_TRAINS-1:0]        req;
  logic [FARE_W*NUM_TRAINS-1:0] req_fare;
  logic                         fault_flag;
  logic [NUM_TRAINS-1:0]        gnt;
  logic [NUM_TRAINS-1:0]        done;
  logic [NUM_TRAINS-1:0]        nack;
  logic [CNT_W-1:0]             booked_count;
  logic [FARE_W-1:0]            fare;
  logic [CNT_W*NUM_TRAINS-1:0]  seat_counts;
  logic                         heal_active;
  logic                         locked;
  logic                         busy;

  modport slave (
    input  req, req_fare, fault_flag,
    output gnt, done, nack, booked_count, fare, seat_counts, heal_active, locked, busy
  );

  modport master (
    output req, req_fare, fault_flag,
    input  gnt, done, nack, booked_count, fare, seat_counts, heal_active, locked, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after the pointer wins (one-hot).
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);
  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/booking_scheduler.sv
// Arbitrates train booking requests, commits seats, and rolls back a booking
// when the external detector flags the committed fare; locks after repeated heals.
module booking_scheduler #(
  parameter int NUM_TRAINS  = booking_pkg::NUM_TRAINS,
  parameter int CAPACITY    = booking_pkg::CAPACITY,
  parameter int LOCK_THRESH = booking_pkg::LOCK_THRESH
) (
  input logic      clk,
  input logic      rst,
  booking_if.slave bus
);
  import booking_pkg::*;

  // state  | meaning
  // IDLE   | arbitrate   COMMIT | grant, bump count   SAMPLE | detector latches
  // CHECK  | read fault  HEAL   | roll back count     LOCKED | dead until reset
  localparam int PW  = idx_w(NUM_TRAINS);
  localparam int FCW = idx_w(LOCK_THRESH + 1);

  state_t                           state_q, state_d;
  logic [PW-1:0]                    winner_q, winner_d, ptr_q, ptr_d, win_idx;
  logic [NUM_TRAINS-1:0]            win_oh, done_q, done_d, nack_q, nack_d, gnt_oh;
  logic [NUM_TRAINS-1:0][CNT_W-1:0] seat_q, seat_d;
  logic [CNT_W-1:0]                 snap_q, snap_d, bcnt_q, bcnt_d, cur_seat;
  logic [FARE_W-1:0]                fare_q, fare_d, cur_fare;
  logic [FCW-1:0]                   fcnt_q, fcnt_d, fcnt_inc;

  rr_arbiter #(.N(NUM_TRAINS), .PW(PW)) u_arb (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .gnt_o (win_oh)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_TRAINS; i++) begin
      if (win_oh[i]) win_idx = PW'(i);
    end
  end

  assign cur_seat = seat_q[winner_q];
  assign cur_fare = bus.req_fare[int'(winner_q)*FARE_W +: FARE_W];
  assign fcnt_inc = fcnt_q + FCW'(1);

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    ptr_d    = ptr_q;
    seat_d   = seat_q;
    snap_d   = snap_q;
    bcnt_d   = bcnt_q;
    fare_d   = fare_q;
    fcnt_d   = fcnt_q;
    done_d   = '0;
    nack_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          winner_d = win_idx;
          ptr_d    = (win_idx == PW'(NUM_TRAINS - 1)) ? '0 : win_idx + PW'(1);
          state_d  = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (cur_seat >= CNT_W'(CAPACITY)) begin
          nack_d[winner_q] = 1'b1;
          state_d          = ST_IDLE;
        end else begin
          snap_d           = cur_seat;
          seat_d[winner_q] = cur_seat + CNT_W'(1);
          bcnt_d           = cur_seat + CNT_W'(1);
          fare_d           = cur_fare;
          state_d          = ST_SAMPLE;
        end
      end
      ST_SAMPLE: state_d = ST_CHECK;
      ST_CHECK: begin
        if (bus.fault_flag) begin
          state_d = ST_HEAL;
        end else begin
          done_d[winner_q] = 1'b1;
          fcnt_d           = '0;
          bcnt_d           = '0;
          fare_d           = '0;
          state_d          = ST_IDLE;
        end
      end
      ST_HEAL: begin
        seat_d[winner_q] = snap_q;
        bcnt_d           = '0;
        fare_d           = '0;
        fcnt_d           = fcnt_inc;
        nack_d[winner_q] = 1'b1;
        state_d          = (fcnt_inc >= FCW'(LOCK_THRESH)) ? ST_LOCKED : ST_IDLE;
      end
      ST_LOCKED: state_d = ST_LOCKED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      winner_q <= '0;
      ptr_q    <= '0;
      seat_q   <= '0;
      snap_q   <= '0;
      bcnt_q   <= '0;
      fare_q   <= '0;
      fcnt_q   <= '0;
      done_q   <= '0;
      nack_q   <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
      seat_q   <= seat_d;
      snap_q   <= snap_d;
      bcnt_q   <= bcnt_d;
      fare_q   <= fare_d;
      fcnt_q   <= fcnt_d;
      done_q   <= done_d;
      nack_q   <= nack_d;
    end
  end

  assign gnt_oh           = NUM_TRAINS'(1) << winner_q;
  assign bus.gnt          = (state_q == ST_COMMIT) ? gnt_oh : '0;
  assign bus.done         = done_q;
  assign bus.nack         = nack_q;
  assign bus.booked_count = bcnt_q;
  assign bus.fare         = fare_q;
  assign bus.seat_counts  = seat_q;
  assign bus.heal_active  = (state_q == ST_HEAL);
  assign bus.locked       = (state_q == ST_LOCKED);
  assign bus.busy         = (state_q != ST_IDLE) && (state_q != ST_LOCKED);
endmodule

// File: tb/tb_booking_scheduler.sv
// Scoreboard bench for booking_scheduler with a behavioural fare detector.
module tb_booking_scheduler;
  import booking_pkg::*;

  localparam int K_OK = 0, K_FULL = 1, K_FAULT = 2;

  typedef struct {
    int kind;   // 0 gnt, 1 done, 2 nack
    int train;
    int lat;    // gnt: cycles after req; done/nack: cycles after gnt; -1 skip
    int seat;
    int heal;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_mis = 0;
  int   req_cyc = 0;
  int   last_gnt_cyc = 0;
  logic prev_heal = 1'b0;
  int   exp_seat [NUM_TRAINS];
  exp_t sbq [$];

  exp_t e;
  int   m_kind, m_tr, m_lat, m_seat;
  logic [NUM_TRAINS-1:0] m_ev;

  booking_if #(.NUM_TRAINS(NUM_TRAINS)) bus();

  booking_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!rst) bus.fault_flag <= 1'b0;
    else      bus.fault_flag <= (int'(bus.fare) > FARE_MAX);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req_v);
    n_vec++;
    if (got !== req_v) begin
      n_mis++;
      $display("FAIL %s: got %0h, required %0h", name, got, req_v);
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctl"}, {bus.gnt, bus.done, bus.nack, bus.heal_active, bus.locked, bus.busy}, 0);
    chk({name, "_seats"}, bus.seat_counts, 0);
    chk({name, "_data"}, {bus.booked_count, bus.fare}, 0);
  endtask

  task automatic clear_model();
    foreach (exp_seat[i]) exp_seat[i] = 0;
  endtask

  task automatic do_reset(input string name);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_zero(name);
    rst = 1'b1;
    clear_model();
  endtask

  task automatic wait_gnt(input int tr);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.gnt[tr]) seen = 1'b1;
    end
    chk("gnt_wait", 64'(seen), 1);
  endtask

  task automatic book(input int tr, input int fv, input int kind);
    logic [14:0] exp_s;
    sbq.push_back('{0, tr, 1, -1, -1});
    if (kind == K_OK) begin
      exp_seat[tr]++;
      sbq.push_back('{1, tr, 3, exp_seat[tr], -1});
      exp_s = {1'b1, 4'(exp_seat[tr]), 10'(fv)};
    end else if (kind == K_FULL) begin
      sbq.push_back('{2, tr, 1, exp_seat[tr], 0});
      exp_s = '0;
    end else begin
      sbq.push_back('{2, tr, 4, exp_seat[tr], 1});
      exp_s = {1'b1, 4'(exp_seat[tr] + 1), 10'(fv)};
    end
    bus.req_fare[tr*FARE_W +: FARE_W] = 10'(fv);
    bus.req[tr] = 1'b1;
    req_cyc = cyc;
    wait_gnt(tr);
    bus.req[tr] = 1'b0;
    @(negedge clk);
    chk("sample_regs", {bus.busy, bus.booked_count, bus.fare}, exp_s);
    repeat (6) @(negedge clk);
  endtask

  task automatic multi(input logic [NUM_TRAINS-1:0] mask, input int ord [4], input int cnt);
    int guard;
    for (int k = 0; k < cnt; k++) begin
      exp_seat[ord[k]]++;
      sbq.push_back('{0, ord[k], (k == 0) ? 1 : -1, -1, -1});
      sbq.push_back('{1, ord[k], 3, exp_seat[ord[k]], -1});
    end
    for (int i = 0; i < NUM_TRAINS; i++)
      if (mask[i]) bus.req_fare[i*FARE_W +: FARE_W] = 10'(100 * (i + 1));
    bus.req = mask;
    req_cyc = cyc;
    guard = 0;
    while (bus.req != 0 && guard < 80) begin
      @(negedge clk);
      bus.req = bus.req & ~bus.gnt;
      guard++;
    end
    chk("multi_drain", 64'(bus.req), 0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    bus.req = '0;
    bus.req_fare = '0;
    clear_model();
    fork
      forever begin
        @(negedge clk);
        if ($countones({bus.gnt, bus.done, bus.nack}) > 1) begin
          n_mis++;
          $display("FAIL onehot: gnt=%b done=%b nack=%b, required at most one bit", bus.gnt, bus.done, bus.nack);
        end
        if (|{bus.gnt, bus.done, bus.nack}) begin
          m_kind = (|bus.gnt) ? 0 : ((|bus.done) ? 1 : 2);
          m_ev   = (m_kind == 0) ? bus.gnt : ((m_kind == 1) ? bus.done : bus.nack);
          m_tr   = 0;
          for (int i = 0; i < NUM_TRAINS; i++) if (m_ev[i]) m_tr = i;
          m_lat  = (m_kind == 0) ? cyc - req_cyc : cyc - last_gnt_cyc;
          m_seat = int'(bus.seat_counts[m_tr*CNT_W +: CNT_W]);
          n_vec++;
          if (sbq.size() == 0) begin
            n_mis++;
            $display("FAIL sb_unexpected: kind=%0d train=%0d, required no event", m_kind, m_tr);
          end else begin
            e = sbq.pop_front();
            if (e.kind != m_kind || e.train != m_tr || (e.lat >= 0 && e.lat != m_lat) ||
                (e.seat >= 0 && e.seat != m_seat) || (e.heal >= 0 && e.heal != int'(prev_heal))) begin
              n_mis++;
              $display("FAIL sb_event: got kind=%0d train=%0d lat=%0d seat=%0d heal=%0d, required kind=%0d train=%0d lat=%0d seat=%0d heal=%0d",
                       m_kind, m_tr, m_lat, m_seat, prev_heal, e.kind, e.train, e.lat, e.seat, e.heal);
            end
          end
          if (m_kind == 0) last_gnt_cyc = cyc;
        end
        prev_heal = bus.heal_active;
      end
      begin
        int ng;
        do_reset("rst_init");
        // single booking, then reset clears the count
        book(0, 500, K_OK);
        do_reset("rst_counts");
        // round robin from pointer 0, then 0 before 2
        multi(4'b1111, '{0, 1, 2, 3}, 4);
        multi(4'b0101, '{0, 2, 0, 0}, 2);
        // fill train 1 to capacity and bounce off it
        for (int i = 0; i < 8; i++) book(1, 100 + i, K_OK);
        book(1, 100, K_FULL);
        chk("seat1_cap", 64'(bus.seat_counts[7:4]), 9);
        // heals; full nack and success affect the fault counter differently
        book(2, 950, K_FAULT);
        book(1, 120, K_FULL);
        book(2, 950, K_FAULT);
        chk("locked_after_2", 64'(bus.locked), 0);
        book(3, 300, K_OK);
        book(2, 950, K_FAULT);
        book(2, 950, K_FAULT);
        chk("locked_mid", 64'(bus.locked), 0);
        book(2, 950, K_FAULT);
        chk("locked_set", {bus.locked, bus.busy}, 2'b10);
        bus.req_fare[9:0] = 10'd500;
        bus.req[0] = 1'b1;
        ng = 0;
        repeat (10) begin
          @(negedge clk);
          if (|bus.gnt) ng++;
        end
        chk("no_gnt_locked", 64'(ng), 0);
        bus.req = '0;
        do_reset("rst_lock");
        // reset mid-transaction, then check the pointer returned to 0
        book(0, 500, K_OK);
        sbq.push_back('{0, 0, 1, -1, -1});
        bus.req_fare[9:0] = 10'd500;
        bus.req[0] = 1'b1;
        req_cyc = cyc;
        wait_gnt(0);
        bus.req[0] = 1'b0;
        @(negedge clk);
        chk("mid_sample", {bus.busy, bus.booked_count, bus.fare}, {1'b1, 4'd2, 10'd500});
        rst = 1'b0;
        @(negedge clk);
        check_zero("rst_sample");
        rst = 1'b1;
        clear_model();
        repeat (6) @(negedge clk);
        multi(4'b0011, '{0, 1, 0, 0}, 2);
        repeat (4) @(negedge clk);
        chk("sb_drained", 64'(sbq.size()), 0);
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/booking_scheduler.md
BOOKING_SCHEDULER -- requirements
Module: booking_scheduler

Interface
REQ-001 Parameters SHALL be NUM_TRAINS (default 4, requester count), CAPACITY (default 9, seats per train) and LOCK_THRESH (default 3, consecutive heals before lockout).
REQ-002 clk  in  1  single clock; all logic on posedge clk.
REQ-003 rst  in  1  reset is synchronous and active-low.
REQ-004 req  in  NUM_TRAINS  per-train booking request; held high until gnt, dropped the cycle after gnt.
REQ-005 req_fare  in  10*NUM_TRAINS  packed fare per train; slice i belongs to train i and is valid while req[i] is high.
REQ-006 fault_flag  in  1  registered fault indication from the fault detector.
REQ-007 gnt  out  NUM_TRAINS  one-hot grant, high for exactly the COMMIT cycle.
REQ-008 done  out  NUM_TRAINS  one-hot one-cycle pulse: booking succeeded.
REQ-009 nack  out  NUM_TRAINS  one-hot one-cycle pulse: booking rejected (train full, or fault healed).
REQ-010 booked_count  out  4  registered seat count under test, to detector.
REQ-011 fare  out  10  registered fare under test, to detector.
REQ-012 seat_counts  out  4*NUM_TRAINS  packed committed seat count per train.
REQ-013 heal_active  out  1  high during the HEAL cycle.
REQ-014 locked  out  1  high while in LOCKED.
REQ-015 busy  out  1  high in any state other than IDLE and LOCKED.

Function
REQ-016 The FSM SHALL have states IDLE, COMMIT, SAMPLE, CHECK, HEAL and LOCKED.
REQ-017 IDLE: when any req bit is high, register the round-robin winner and go to COMMIT; otherwise stay in IDLE.
REQ-018 Round robin: after reset, train 0 has highest priority; after any grant to train i, train (i+1) mod NUM_TRAINS has highest priority, whatever the outcome.
REQ-019 COMMIT: assert gnt[winner]; if seat_counts[winner] == CAPACITY, pulse nack[winner] in the next cycle and return to IDLE with no count change.
REQ-020 COMMIT, not full: save the old count as a snapshot, increment seat_counts[winner], register booked_count = new count and fare = req_fare slice, then go to SAMPLE.
REQ-021 SAMPLE: hold booked_count and fare for one cycle while the detector registers them, then go to CHECK.
REQ-022 CHECK, fault_flag low: pulse done[winner] next cycle, clear the consecutive-fault counter, clear booked_count and fare to 0, go to IDLE.
REQ-023 CHECK, fault_flag high: go to HEAL.
REQ-024 HEAL: restore seat_counts[winner] from the snapshot, assert heal_active, clear booked_count and fare, increment the consecutive-fault counter and pulse nack[winner] next cycle.
REQ-025 HEAL exit: if the fault counter has reached LOCK_THRESH, go to LOCKED; otherwise go to IDLE.
REQ-026 Latency from req sampled in IDLE (cycle t): gnt at t+1; full-nack at t+2; done at t+4; fault-nack at t+5.
REQ-027 A nack caused by a full train SHALL NOT change the fault counter.
REQ-028 LOCKED: no grants, done or nack; locked=1; exit only by reset.
REQ-029 Requests arriving while busy SHALL be held and arbitrated at the next IDLE, with no loss.
REQ-030 Seat counts SHALL never exceed CAPACITY and never wrap.
REQ-031 At most one bit of gnt, done and nack combined SHALL be high in any cycle.

Reset
REQ-032 With rst low at a clock edge, the state SHALL go to IDLE, and seat_counts, snapshot, fault counter, booked_count, fare, gnt, done, nack, heal_active and locked SHALL all clear to 0.
REQ-033 The priority pointer SHALL reset to train 0.
REQ-034 A reset mid-transaction SHALL drop the transaction with no done or nack pulse.

Structure
REQ-035 Shared package booking_pkg SHALL hold NUM_TRAINS, CAPACITY, FARE_MAX=900, LOCK_THRESH and the state enumeration.
REQ-036 Round-robin selection SHALL be a sub-module named rr_arbiter (request vector, pointer -> one-hot winner), with the pointer register kept in booking_scheduler.
REQ-037 The fault detector SHALL be instantiated outside this block; only booked_count, fare and fault_flag cross the boundary.

Verification
REQ-038 Single req[0], fare 500, detector fault-free -> gnt[0] at t+1, done[0] at t+4, seat_counts[0]=1.
REQ-039 req=4'b1111 held, one booking each -> grants in order 0,1,2,3; a subsequent req[0]|req[2] grants 0 before 2.
REQ-040 Train 1 at count 9, req[1] -> nack[1] at t+2, count stays 9, no heal_active, fault counter unchanged.
REQ-041 req[2] with fare 950 -> fault_flag high in CHECK, heal_active pulse, nack[2] at t+5, seat_counts[2] restored to its prior value.
REQ-042 Three consecutive fare-950 requests -> locked=1 after the third heal; further reqs get no gnt; rst low clears locked and all counts.
REQ-043 rst low during SAMPLE -> next cycle in IDLE, all outputs 0, no done or nack pulse.
